// File: rtl/fila_pkg.sv
// fila_pkg: shared types and width helpers for the fila_param FIFO.
package fila_pkg;
   typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fila_state_t;
   function automatic int fila_clog2(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/fila_rise_det.sv
// fila_rise_det: single-bit rising-edge detector with registered history and synchronous reset.
module fila_rise_det (
   input  logic clock_10KHz,
   input  logic reset,
   input  logic sig,
   output logic rise
);
   logic sig_q;
   always_ff @(posedge clock_10KHz)
      sig_q <= reset ? 1'b0 : sig;
   assign rise = sig & ~sig_q;
endmodule

// File: rtl/fila_param.sv
// fila_param: parametrised circular FIFO with edge-triggered enqueue/dequeue, flags and sticky errors.
// Define FILA_PEEK_EN to add peek_out, the head word shown without dequeuing.
module fila_param
   import fila_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH = 8,
   localparam int AW = fila_clog2(DEPTH),
   localparam int LEN_W = fila_clog2(DEPTH + 1)
) (
   input  logic              clock_10KHz,
   input  logic              reset,
   input  logic              clear_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic              enqueue_in,
   input  logic              dequeue_in,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic [LEN_W-1:0]  len_out,
   output logic              full_out,
   output logic              empty_out,
   output logic              overflow_out,
   output logic              underflow_out
`ifdef FILA_PEEK_EN
   ,
   output logic [DATA_W-1:0] peek_out
`endif
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LEN_W-1:0] len;
   fila_state_t state, state_nxt;
   logic enq_req, deq_req, do_enq, do_deq;

   fila_rise_det u_enq_det (.clock_10KHz, .reset, .sig(enqueue_in), .rise(enq_req));
   fila_rise_det u_deq_det (.clock_10KHz, .reset, .sig(dequeue_in), .rise(deq_req));

   assign full_out  = state == FULL;
   assign empty_out = state == EMPTY;
   assign len_out   = len;
   assign do_deq    = deq_req & ~empty_out;
   // a dequeue in the same cycle frees the slot a full FIFO needs for the write
   assign do_enq    = enq_req & (~full_out | do_deq);

`ifdef FILA_PEEK_EN
   assign peek_out = empty_out ? '0 : mem[rd_ptr];
`endif

   always_comb begin
      state_nxt = state;
      if (clear_in)
         state_nxt = EMPTY;
      else if (do_enq && !do_deq)
         state_nxt = (len == LEN_W'(DEPTH - 1)) ? FULL : PARTIAL;
      else if (do_deq && !do_enq)
         state_nxt = (len == LEN_W'(1)) ? EMPTY : PARTIAL;
   end

   always_ff @(posedge clock_10KHz)
      state <= reset ? EMPTY : state_nxt;

   always_ff @(posedge clock_10KHz)
      if (do_enq && !reset && !clear_in) mem[wr_ptr] <= data_in;

   always_ff @(posedge clock_10KHz) begin
      if (reset || clear_in) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         len           <= '0;
         data_out      <= '0;
         valid_out     <= 1'b0;
         overflow_out  <= 1'b0;
         underflow_out <= 1'b0;
      end else begin
         if (do_enq) wr_ptr <= wr_ptr + AW'(1);
         if (do_deq) rd_ptr <= rd_ptr + AW'(1);
         len           <= len + LEN_W'(do_enq) - LEN_W'(do_deq);
         valid_out     <= do_deq;
         if (do_deq) data_out <= mem[rd_ptr];
         else if (deq_req) data_out <= '0;
         overflow_out  <= overflow_out | (enq_req & full_out & ~deq_req);
         underflow_out <= underflow_out | (deq_req & empty_out);
      end
   end

   assert property (@(posedge clock_10KHz) disable iff (reset)
      ((state == EMPTY) == (len == '0)) && ((state == FULL) == (len == LEN_W'(DEPTH))));
endmodule

// File: doc/fila_param.md
Name: fila_param

Overview:
Parametrised circular FIFO (first-in first-out) queue, the successor to the team's fixed 8x8 queue. Width and depth are generics. Enqueue and dequeue requests are rising-edge triggered and can be serviced together in the same cycle. The block adds full/empty flags, a data-valid pulse, sticky overflow/underflow errors and a synchronous flush. It sits between the 10 kHz control logic and its data consumers.

Parameters:
DATA_W, 8, width of each stored word in bits
DEPTH, 8, number of entries; must be a power of two, >= 2
AW (localparam), $clog2(DEPTH), pointer width
LEN_W (localparam), $clog2(DEPTH+1), occupancy width; holds 0..DEPTH without wrap

Ports:
clock_10KHz  in   1       system clock; all logic on its rising edge
reset        in   1       synchronous, active-high reset
clear_in     in   1       synchronous flush (level)
data_in      in   DATA_W  word to enqueue
enqueue_in   in   1       enqueue request; acted on at its rising edge
dequeue_in   in   1       dequeue request; acted on at its rising edge
data_out     out  DATA_W  last dequeued word (registered)
valid_out    out  1       1-cycle pulse: data_out updated with a real word
len_out      out  LEN_W   current occupancy
full_out     out  1       len_out == DEPTH
empty_out    out  1       len_out == 0
overflow_out out  1       sticky: an enqueue was attempted while full
underflow_out out 1       sticky: a dequeue was attempted while empty

Behaviour:
- Reset (sync, active-high) sets: state=EMPTY, pointers=0, len_out=0, data_out=0, valid_out=0, empty_out=1, full_out=0, overflow_out=0, underflow_out=0, and both edge-history registers=0. Storage array is not reset.
- Edge detection: enq_req = enqueue_in & ~enq_q and deq_req = dequeue_in & ~deq_q, where enq_q/deq_q hold the previous cycle's inputs.
  - A level held high produces exactly one request.
  - A level that is high when reset releases counts as a rising edge on the first cycle after reset.
- Enqueue: on the edge where enq_req=1 and the FIFO is not full (or a dequeue occurs in the same cycle):
  - mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH.
  - Visible in len_out one cycle after the request is sampled.
- Dequeue: on the edge where deq_req=1 and the FIFO is not empty:
  - data_out <= mem[rd_ptr]; rd_ptr increments modulo DEPTH; valid_out=1 for that single cycle.
  - Latency: data is valid in the cycle after the rising edge of dequeue_in.
- Occupancy: len_out +1 on enqueue only, -1 on dequeue only, unchanged when both occur.
- Full and enqueue only: the word is dropped, overflow_out set, len_out unchanged.
- Empty and dequeue only: data_out <= 0, valid_out=0, underflow_out set, pointers unchanged.
- Simultaneous requests:
  - Full: both performed (read old head, write into the freed slot); len stays DEPTH; no overflow.
  - Empty: enqueue performed, dequeue flagged as underflow; no bypass; data_out <= 0; len becomes 1.
  - Partial: both performed.
- clear_in=1 has priority over all requests that cycle:
  - Pointers=0, len_out=0, state=EMPTY, data_out=0, valid_out=0, sticky errors cleared.
  - Edge-history registers still update, so an input held high through clear does not re-trigger.
- State machine (package enum), registered, with full_out/empty_out decoded from it:
  - EMPTY -> PARTIAL on enqueue (DEPTH>=2).
  - PARTIAL -> FULL when len goes DEPTH-1 -> DEPTH.
  - PARTIAL -> EMPTY when len goes 1 -> 0.
  - FULL -> PARTIAL on dequeue only.
  - Simultaneous enqueue and dequeue leaves the state unchanged, except EMPTY -> PARTIAL.
  - Invariant (to be asserted): state always agrees with len_out.
- The sticky errors only clear on reset or clear_in.

Optional Feature:
FILA_PEEK_EN:
- Defined: adds an output peek_out [DATA_W] = mem[rd_ptr], combinational from the registered pointer. It shows the head word without removing it. peek_out is 0 when empty_out=1.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package fila_pkg holds:
  - the typedef fila_state_t {EMPTY, PARTIAL, FULL};
  - the function clog2-safe width helpers.
- One sub-module, fila_rise_det: a single-bit registered rising-edge detector with synchronous reset. It is instantiated twice, once for enqueue and once for dequeue.

Test Plan:
(All scenarios use DATA_W=8, DEPTH=8.)
1. Reset, then pulse enqueue with data 0x11, 0x22, 0x33 -> len_out = 1, 2, 3 after each pulse. Then 3 dequeue pulses -> data_out = 0x11, 0x22, 0x33, each with a 1-cycle valid_out, and empty_out=1 at the end.
2. 8 enqueues (0xA0..0xA7) -> full_out=1, len_out=8. A 9th enqueue of 0xFF -> overflow_out=1 and len_out stays 8. Drain 8 -> 0xA0..0xA7 in order; 0xFF never appears.
3. Dequeue when empty -> data_out=0x00, valid_out=0, underflow_out=1. Assert clear_in -> underflow_out=0.
4. Wrap-around: enqueue 6, dequeue 6, enqueue 5 (0x50..0x54) -> dequeue yields 0x50..0x54. Checks pointer wrap modulo 8.
5. Full FIFO, raise enqueue_in (0xEE) and dequeue_in in the same cycle -> data_out=old head, len_out stays 8, overflow_out=0. A later drain ends with 0xEE. Also hold enqueue_in high for 5 cycles -> exactly one write.
6. Mid-operation: after 4 enqueues, pulse reset for one cycle while enqueue_in=1 -> all outputs return to their reset values. Then, with enqueue_in still high on release, exactly one enqueue is taken (len_out=1).
